xosera_bus_master: RTL and testbench
====================================

# xosera_bus_master

Host-side initiator for the Xosera 8-bit register bus. It accepts 16-bit register read and write requests on a valid/ready handshake. Each request runs as two chip-select byte cycles: even (high) byte first, then odd (low) byte. The block also synchronizes the Xosera interrupt line. It sits at the CPU/softcore or bring-up-sequencer end of the bus and drives the same `bus_*` pins that Xosera receives.

## Interface

Parameters (each legal range 1..255):

- `CS_SETUP`, default 1: cycles the address, control and write data are stable with `bus_cs_n_o` high before the strobe.
- `CS_WIDTH`, default 4: cycles `bus_cs_n_o` is held low per byte.
- `CS_HOLD`, default 2: cycles `bus_cs_n_o` is high after the strobe, with address and data still held.

Ports:

- `clk` in 1: the single clock.
- `reset_i` in 1: reset, asynchronous and active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: high only in IDLE; a request is accepted when valid and ready are both high.
- `req_rd_nwr_i` in 1: 1 = read, 0 = write.
- `req_reg_num_i` in 4: register number.
- `req_data_i` in 16: write data; [15:8] is the even byte.
- `rsp_valid_o` out 1: one-cycle completion pulse, for both reads and writes.
- `rsp_data_o` out 16: read data; holds its value until the next read completes.
- `busy_o` out 1: high whenever the state is not IDLE.
- `bus_cs_n_o` out 1: chip select, active low.
- `bus_rd_nwr_o` out 1: 1 = read, 0 = write.
- `bus_reg_num_o` out 4: register number.
- `bus_bytesel_o` out 1: 0 = even byte, 1 = odd byte.
- `bus_data_o` out 8: write byte.
- `bus_data_oe_o` out 1: data output enable.
- `bus_data_i` in 8: read byte.
- `bus_intr_i` in 1: asynchronous Xosera interrupt line.
- `intr_o` out 1: one-cycle pulse on each synchronized rising edge of `bus_intr_i`.

## Operation

States and transitions:
- IDLE → SETUP on acceptance.
- SETUP → STROBE → HOLD.
- HOLD with byte index 0 → SETUP with byte index 1.
- HOLD with byte index 1 → IDLE.
- One shared 8-bit down-counter times each phase; it loads N-1 on phase entry and leaves the phase at 0.

On acceptance the block latches rd_nwr, reg_num and data. The `req_*` inputs are ignored at all other times.

Bus drive while not IDLE:
- `bus_rd_nwr_o` and `bus_reg_num_o` = the latched values.
- `bus_bytesel_o` = the byte index.
- `bus_data_o` = latched data [15:8] for byte 0, [7:0] for byte 1.
- `bus_data_oe_o` = 1 for writes throughout SETUP, STROBE and HOLD; 0 for reads.
- `bus_cs_n_o` = 0 only in STROBE.

In IDLE:
- `bus_cs_n_o` = 1 and `bus_data_oe_o` = 0.
- All other `bus_*` outputs hold their last values.

Read capture:
- `bus_data_i` is registered on the clock edge that ends the last STROBE cycle.
- Byte 0 goes to a staging [15:8], byte 1 to [7:0].
- `rsp_data_o` updates from the staging register on entry to IDLE after a read.

Completion:
- `rsp_valid_o` = 1 in the first IDLE cycle after byte 1 HOLD.
- `req_ready_o` is also 1 in that cycle, so a back-to-back acceptance is legal.

Interrupt path:
- Two-flop synchronizer, then a registered edge detector.
- `intr_o` = sync2 & ~sync3.
- A held-high input produces exactly one pulse.

## Timing

- Reset values: `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0, `bus_data_oe_o`=0, `req_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `busy_o`=0, `intr_o`=0. The synchronizer flops also reset to 0.
- Reset asserted mid-transaction: `bus_cs_n_o` goes high and `bus_data_oe_o` goes low immediately (asynchronously). No `rsp_valid_o` is issued, and the request is dropped.
- Let T = CS_SETUP + CS_WIDTH + CS_HOLD, and take the acceptance cycle as cycle 0.
  - Byte 0 occupies cycles 1..T; byte 1 occupies cycles T+1..2T.
  - `rsp_valid_o` is high in cycle 2T+1.
  - With defaults T=7, so `rsp_valid_o` is high in cycle 15.
- Minimum `bus_cs_n_o` high time between the two strobes, and between back-to-back requests, is CS_HOLD + CS_SETUP cycles.
- `intr_o` goes high 2-3 clk cycles after `bus_intr_i` rises. The exact cycle depends on when the rise lands relative to the sampling edge.

## Test plan

- **Reset:** assert `reset_i` asynchronously between clock edges → every output takes its reset value before the next edge; after release, `req_ready_o`=1.
- **Default write:** write reg 3, data 0xA55A.
  - Two `bus_cs_n_o` low pulses, each 4 cycles, in cycles 2-5 and 9-12.
  - bytesel 0 with data 0xA5, then bytesel 1 with data 0x5A.
  - `bus_data_oe_o`=1 over cycles 1-14, `bus_rd_nwr_o`=0.
  - `rsp_valid_o` pulses in cycle 15.
- **Read:** read reg 0xC against a responder model driving 0x12 for bytesel 0 and 0x34 for bytesel 1 → `bus_data_oe_o`=0 throughout; `rsp_data_o`=0x1234 in cycle 15 and it holds through a following write.
- **Back-to-back and mid-operation reset:**
  - Hold `req_valid_i` high for two writes → second is accepted in the `rsp_valid_o` cycle; cs_n stays high for ≥3 cycles between strobes.
  - Separately, pulse `reset_i` during byte 0 STROBE → `bus_cs_n_o`=1 at once, no `rsp_valid_o`.
- **Non-default timing:** build with CS_SETUP=2, CS_WIDTH=1, CS_HOLD=1 → a single-cycle strobe in cycles 3 and 7; `rsp_valid_o` in cycle 9; read data is still captured correctly.
- **Interrupt:**
  - `bus_intr_i` high for 5 cycles → exactly one `intr_o` pulse, 2-3 cycles after the rise.
  - `bus_intr_i` held high → no further pulses.
  - Low for 3+ cycles then high again → a second pulse.

Source files
------------

// File: rtl/xosera_bus_master.sv
// xosera_bus_master: 16-bit valid/ready register reads/writes as two byte cycles on the Xosera bus,
// plus a synchronizer and rising-edge pulse for the Xosera interrupt line.
module xosera_bus_master #(
    parameter int CS_SETUP = 1,
    parameter int CS_WIDTH = 4,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_nwr_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        busy_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i,
    input  logic        bus_intr_i,
    output logic        intr_o
);
    localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3;
    localparam logic [7:0] SETUP_N = 8'(CS_SETUP - 1);
    localparam logic [7:0] WIDTH_N = 8'(CS_WIDTH - 1);
    localparam logic [7:0] HOLD_N  = 8'(CS_HOLD - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        byte_q, byte_d;
    logic        rd_nwr_q, rd_nwr_d;
    logic [3:0]  reg_q, reg_d;
    logic [15:0] data_q, data_d;
    logic [15:0] stage_q, stage_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [2:0]  sync_q;
    logic        accept, last;

    assign req_ready_o = state_q == IDLE;
    assign accept      = req_valid_i & req_ready_o;
    assign last        = cnt_q == 8'd0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE || last) ? cnt_q : cnt_q - 8'd1;
        byte_d      = byte_q;
        rd_nwr_d    = rd_nwr_q;
        reg_d       = reg_q;
        data_d      = data_q;
        stage_d     = stage_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d  = SETUP;
                cnt_d    = SETUP_N;
                byte_d   = 1'b0;
                rd_nwr_d = req_rd_nwr_i;
                reg_d    = req_reg_num_i;
                data_d   = req_data_i;
            end
            SETUP: if (last) begin
                state_d = STROBE;
                cnt_d   = WIDTH_N;
            end
            STROBE: if (last) begin
                state_d = HOLD;
                cnt_d   = HOLD_N;
                stage_d = byte_q ? {stage_q[15:8], bus_data_i} : {bus_data_i, stage_q[7:0]};
            end
            default: if (last) begin
                // byte 0 loops back for the odd byte; byte 1 completes the request
                state_d     = byte_q ? IDLE : SETUP;
                cnt_d       = SETUP_N;
                byte_d      = 1'b1;
                rsp_valid_d = byte_q;
                rsp_data_d  = (byte_q && rd_nwr_q) ? stage_q : rsp_data_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            byte_q      <= 1'b0;
            rd_nwr_q    <= 1'b1;
            reg_q       <= 4'd0;
            data_q      <= 16'd0;
            stage_q     <= 16'd0;
            rsp_data_q  <= 16'd0;
            rsp_valid_q <= 1'b0;
            sync_q      <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            rd_nwr_q    <= rd_nwr_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            stage_q     <= stage_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            sync_q      <= {sync_q[1:0], bus_intr_i};
        end
    end

    assign busy_o        = state_q != IDLE;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign bus_cs_n_o    = state_q != STROBE;
    assign bus_data_oe_o = state_q != IDLE && !rd_nwr_q;
    assign bus_rd_nwr_o  = rd_nwr_q;
    assign bus_reg_num_o = reg_q;
    assign bus_bytesel_o = byte_q;
    assign bus_data_o    = byte_q ? data_q[7:0] : data_q[15:8];
    assign intr_o        = sync_q[1] & ~sync_q[2];
endmodule

// File: tb/tb_xosera_bus_master.sv
// tb_xosera_bus_master: directed requests on a default and a fast-timing instance, scoreboarded
// bus traces and responses, mid-transaction reset and interrupt edge pulses.
module tb_xosera_bus_master;
    typedef struct {
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;

    logic        reset_i, req_valid_i, req_rd_nwr_i, req_ready_o, rsp_valid_o, busy_o;
    logic [3:0]  req_reg_num_i, bus_reg_num_o;
    logic [15:0] req_data_i, rsp_data_o;
    logic        bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o, bus_intr_i, intr_o;
    logic [7:0]  bus_data_o, bus_data_i;

    logic        b_reset_i, b_req_valid_i, b_req_rd_nwr_i, b_req_ready_o, b_rsp_valid_o, b_busy_o;
    logic [3:0]  b_req_reg_num_i, b_bus_reg_num_o;
    logic [15:0] b_req_data_i, b_rsp_data_o;
    logic        b_bus_cs_n_o, b_bus_rd_nwr_o, b_bus_bytesel_o, b_bus_data_oe_o, b_bus_intr_i, b_intr_o;
    logic [7:0]  b_bus_data_o, b_bus_data_i;

    // responder models: fixed bytes per byte lane
    assign bus_data_i   = bus_bytesel_o ? 8'h34 : 8'h12;
    assign b_bus_data_i = b_bus_bytesel_o ? 8'hEF : 8'hBE;

    xosera_bus_master u0 (
        .clk(clk), .reset_i(reset_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rd_nwr_i(req_rd_nwr_i), .req_reg_num_i(req_reg_num_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o),
        .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o), .bus_reg_num_o(bus_reg_num_o),
        .bus_bytesel_o(bus_bytesel_o), .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
        .bus_data_i(bus_data_i), .bus_intr_i(bus_intr_i), .intr_o(intr_o)
    );

    xosera_bus_master #(.CS_SETUP(2), .CS_WIDTH(1), .CS_HOLD(1)) u1 (
        .clk(clk), .reset_i(b_reset_i), .req_valid_i(b_req_valid_i), .req_ready_o(b_req_ready_o),
        .req_rd_nwr_i(b_req_rd_nwr_i), .req_reg_num_i(b_req_reg_num_i), .req_data_i(b_req_data_i),
        .rsp_valid_o(b_rsp_valid_o), .rsp_data_o(b_rsp_data_o), .busy_o(b_busy_o),
        .bus_cs_n_o(b_bus_cs_n_o), .bus_rd_nwr_o(b_bus_rd_nwr_o), .bus_reg_num_o(b_bus_reg_num_o),
        .bus_bytesel_o(b_bus_bytesel_o), .bus_data_o(b_bus_data_o), .bus_data_oe_o(b_bus_data_oe_o),
        .bus_data_i(b_bus_data_i), .bus_intr_i(b_bus_intr_i), .intr_o(b_intr_o)
    );

    logic [15:0] trace_q0[$], trace_q1[$];
    rsp_t        rsp_q0[$], rsp_q1[$];
    logic [15:0] last_rd0 = 16'h0, last_rd1 = 16'h0;
    int          rsp_cnt0 = 0, intr_cnt = 0, intr_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // u0 monitor: per-cycle bus trace, idle bus state, responses, interrupt pulses
    logic [15:0] e0;
    rsp_t        r0;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (busy_o) begin
                if (trace_q0.size() == 0) chk("trace0_underflow", 32'd1, 32'd0);
                else begin
                    e0 = trace_q0.pop_front();
                    chk("trace0", {16'h0, bus_cs_n_o, bus_data_oe_o, bus_rd_nwr_o, bus_reg_num_o,
                                   bus_bytesel_o, bus_data_o}, {16'h0, e0});
                end
            end else chk("idle0", {30'h0, bus_cs_n_o, bus_data_oe_o}, 32'h2);
            if (rsp_valid_o) begin
                rsp_cnt0++;
                if (rsp_q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
                else begin
                    r0 = rsp_q0.pop_front();
                    chk("rsp0_data", {16'h0, rsp_data_o}, {16'h0, r0.data});
                    chk("rsp0_cycle", cyc, r0.cyc);
                end
            end
            if (intr_o) begin
                intr_cnt++;
                intr_cyc = cyc;
            end
        end
    end

    logic [15:0] e1;
    rsp_t        r1;
    always @(negedge clk) begin
        if (!b_reset_i) begin
            if (b_busy_o) begin
                if (trace_q1.size() == 0) chk("trace1_underflow", 32'd1, 32'd0);
                else begin
                    e1 = trace_q1.pop_front();
                    chk("trace1", {16'h0, b_bus_cs_n_o, b_bus_data_oe_o, b_bus_rd_nwr_o, b_bus_reg_num_o,
                                   b_bus_bytesel_o, b_bus_data_o}, {16'h0, e1});
                end
            end else chk("idle1", {30'h0, b_bus_cs_n_o, b_bus_data_oe_o}, 32'h2);
            if (b_rsp_valid_o) begin
                if (rsp_q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
                else begin
                    r1 = rsp_q1.pop_front();
                    chk("rsp1_data", {16'h0, b_rsp_data_o}, {16'h0, r1.data});
                    chk("rsp1_cycle", cyc, r1.cyc);
                end
            end
        end
    end

    // u=0: default timing (1/4/2, response at cycle 15); u=1: 2/1/1, response at cycle 9
    task automatic issue(input bit u, input logic rd, input logic [3:0] r, input logic [15:0] d,
                         input bit keep);
        int s, w, t, n, p, lat;
        logic b;
        logic [15:0] e;
        rsp_t x;
        s   = u ? 2 : 1;
        w   = u ? 1 : 4;
        t   = u ? 4 : 7;
        lat = u ? 9 : 15;
        @(negedge clk);
        if (u) begin
            b_req_valid_i = 1'b1; b_req_rd_nwr_i = rd; b_req_reg_num_i = r; b_req_data_i = d;
        end else begin
            req_valid_i = 1'b1; req_rd_nwr_i = rd; req_reg_num_i = r; req_data_i = d;
        end
        n = 0;
        while (!(u ? b_req_ready_o : req_ready_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd1, 32'd0);
        for (int k = 1; k <= 2 * t; k++) begin
            b = k > t;
            p = (k - 1) % t;
            e = {!(p >= s && p < s + w), !rd, rd, r, b, b ? d[7:0] : d[15:8]};
            if (u) trace_q1.push_back(e); else trace_q0.push_back(e);
        end
        if (u) begin
            if (rd) last_rd1 = 16'hBEEF;
            x.data = last_rd1;
        end else begin
            if (rd) last_rd0 = 16'h1234;
            x.data = last_rd0;
        end
        x.cyc = cyc + lat;
        if (u) rsp_q1.push_back(x); else rsp_q0.push_back(x);
        @(posedge clk);
        #1;
        if (!keep) begin
            if (u) b_req_valid_i = 1'b0; else req_valid_i = 1'b0;
        end
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while ((trace_q0.size() + trace_q1.size() + rsp_q0.size() + rsp_q1.size()) != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain", trace_q0.size() + trace_q1.size() + rsp_q0.size() + rsp_q1.size(), 0);
    endtask

    function automatic logic [31:0] rst_vec();
        return {12'h0, bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o,
                bus_data_oe_o, req_ready_o, rsp_valid_o, busy_o, intr_o};
    endfunction
    localparam logic [31:0] RST_EXP = {12'h0, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int n, c0, rise;
        reset_i = 1'b1; b_reset_i = 1'b1;
        req_valid_i = 1'b0; req_rd_nwr_i = 1'b0; req_reg_num_i = 4'h0; req_data_i = 16'h0;
        b_req_valid_i = 1'b0; b_req_rd_nwr_i = 1'b0; b_req_reg_num_i = 4'h0; b_req_data_i = 16'h0;
        bus_intr_i = 1'b0; b_bus_intr_i = 1'b0;
        #2;
        chk("por_outputs", rst_vec(), RST_EXP);
        chk("por_rsp_data", {16'h0, rsp_data_o}, 32'h0);
        @(posedge clk); @(posedge clk); #2;
        reset_i = 1'b0; b_reset_i = 1'b0;
        #1 chk("ready_after_reset", {31'h0, req_ready_o}, 32'd1);

        issue(0, 1'b0, 4'h3, 16'hA55A, 1'b0);
        issue(0, 1'b1, 4'hC, 16'h0000, 1'b0);
        issue(0, 1'b0, 4'h5, 16'h0F0F, 1'b0);
        issue(0, 1'b0, 4'h1, 16'h1111, 1'b1);
        issue(0, 1'b0, 4'h2, 16'h2222, 1'b0);
        issue(1, 1'b0, 4'h7, 16'hC3A5, 1'b0);
        issue(1, 1'b1, 4'h9, 16'h0000, 1'b0);
        issue(1, 1'b0, 4'h2, 16'h0001, 1'b0);
        drain(200);

        issue(0, 1'b0, 4'h4, 16'hDEAD, 1'b0);
        n = 0;
        while (bus_cs_n_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_seen", {31'h0, bus_cs_n_o}, 32'd0);
        c0 = rsp_cnt0;
        #2 reset_i = 1'b1;
        #1;
        chk("midop_reset_outputs", rst_vec(), RST_EXP);
        chk("midop_reset_rsp_data", {16'h0, rsp_data_o}, 32'h0);
        trace_q0.delete();
        rsp_q0.delete();
        last_rd0 = 16'h0;
        @(posedge clk);
        #2 reset_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_rsp_after_reset", rsp_cnt0, c0);
        issue(0, 1'b1, 4'hC, 16'h0000, 1'b0);
        drain(100);

        c0 = intr_cnt;
        @(negedge clk);
        bus_intr_i = 1'b1;
        rise = cyc;
        repeat (5) @(negedge clk);
        bus_intr_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("intr_one_pulse", intr_cnt - c0, 1);
        chk("intr_latency", {31'h0, 1'((intr_cyc - rise) >= 2 && (intr_cyc - rise) <= 3)}, 32'd1);
        bus_intr_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("intr_held_high", intr_cnt - c0, 2);
        bus_intr_i = 1'b0;
        repeat (4) @(negedge clk);
        bus_intr_i = 1'b1;
        rise = cyc;
        repeat (6) @(negedge clk);
        chk("intr_second_pulse", intr_cnt - c0, 3);
        chk("intr_latency2", {31'h0, 1'((intr_cyc - rise) >= 2 && (intr_cyc - rise) <= 3)}, 32'd1);
        bus_intr_i = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
